// File: rtl/core_pkg.sv
// ============================================================================
// Module   : core_pkg
// Purpose  : Shared types and constants for the multi-cycle core stages.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package core_pkg;

    typedef enum logic [1:0] {
        MS_BYTE = 2'd0,
        MS_HALF = 2'd1,
        MS_WORD = 2'd2
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } mem_fsm_t;

    localparam logic [2:0] STATE_MEM = 3'd3;

    // Encoding 3 of the size field is an alias for a word access.
    function automatic mem_size_t norm_size(input logic [1:0] size);
        case (size)
            2'd0:    norm_size = MS_BYTE;
            2'd1:    norm_size = MS_HALF;
            default: norm_size = MS_WORD;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/load_align.sv
// ============================================================================
// Module   : load_align
// Purpose  : Selects the addressed lane of a 32-bit read word and extends it.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_align
    import core_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  mem_size_t   size,
    input  logic        is_unsigned,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        case (size)
            MS_BYTE: data = {{24{byte_sel[7] & ~is_unsigned}}, byte_sel};
            MS_HALF: data = {{16{half_sel[15] & ~is_unsigned}}, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
// ============================================================================
// Module   : mem_stage
// Purpose  : Memory-access stage: one load/store per sequencer entry, lane
//            alignment and write-back hand-off. MEM_ALIGN_CHECK_EN enables
//            misaligned-access faulting.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage
    import core_pkg::*;
#(
    parameter logic [2:0] MEM_STATE = STATE_MEM
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  state,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic        reg_write_in,
    input  logic [4:0]  write_reg_in,
    input  logic        writef_in,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_write_data,
    input  logic [31:0] reg_write_data,
    input  logic [1:0]  mem_size,
    input  logic        load_unsigned,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        reg_write_out,
    output logic [4:0]  write_reg_out,
    output logic        writef_out,
    output logic [31:0] wb_data,
    output logic        mem_done,
    output logic        busy,
    output logic        mem_fault
);

    mem_fsm_t    fsm_q, fsm_d;
    logic        armed_q, armed_d;

    logic        rd_q, rd_d;
    logic        st_q, st_d;
    logic        rw_q, rw_d;
    logic [4:0]  wreg_q, wreg_d;
    logic        wf_q, wf_d;
    logic [29:0] word_addr_q, word_addr_d;
    logic [1:0]  off_q, off_d;
    mem_size_t   size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rwdata_q, rwdata_d;

    logic [31:0] wb_data_q, wb_data_d;
    logic        rwo_q, rwo_d;
    logic [4:0]  wro_q, wro_d;
    logic        wfo_q, wfo_d;
    logic        fault_q, fault_d;

    mem_size_t   in_size;
    logic [1:0]  in_off;
    logic        in_access;
    logic        in_fault;
    logic        start;
    logic        handshake;
    logic [31:0] load_data;

    always_comb begin
        in_size   = norm_size(mem_size);
        in_access = mem_read_in | mem_write_in;
        case (in_size)
            MS_BYTE: in_off = mem_addr[1:0];
            MS_HALF: in_off = {mem_addr[1], 1'b0};
            default: in_off = 2'b00;
        endcase
`ifdef MEM_ALIGN_CHECK_EN
        in_fault = in_access &
                   (((in_size == MS_HALF) & mem_addr[0]) |
                    ((in_size == MS_WORD) & (mem_addr[1:0] != 2'b00)));
`else
        in_fault = 1'b0;
`endif
        start     = (fsm_q == IDLE) & (state == MEM_STATE) & ~armed_q;
        handshake = (fsm_q == REQ) & dmem_ready;
    end

    load_align u_load_align (
        .rdata       (dmem_rdata),
        .addr_lo     (off_q),
        .size        (size_q),
        .is_unsigned (uns_q),
        .data        (load_data)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q <= IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    // Next-state logic
    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            IDLE: begin
                if (start) begin
                    fsm_d = (in_access & ~in_fault) ? REQ : DONE;
                end
            end
            REQ: begin
                if (dmem_ready) begin
                    fsm_d = DONE;
                end
            end
            DONE:    fsm_d = IDLE;
            default: fsm_d = IDLE;
        endcase
    end

    // Outputs decoded from state; the bus is quiet outside REQ.
    always_comb begin
        dmem_req   = (fsm_q == REQ);
        dmem_we    = dmem_req & st_q;
        dmem_addr  = dmem_req ? {word_addr_q, 2'b00} : 32'd0;
        dmem_be    = 4'b0000;
        dmem_wdata = 32'd0;
        if (dmem_req) begin
            case (size_q)
                MS_BYTE: begin
                    dmem_be    = 4'b0001 << off_q;
                    dmem_wdata = {4{wdata_q[7:0]}};
                end
                MS_HALF: begin
                    dmem_be    = 4'b0011 << off_q;
                    dmem_wdata = {2{wdata_q[15:0]}};
                end
                default: begin
                    dmem_be    = 4'b1111;
                    dmem_wdata = wdata_q;
                end
            endcase
        end
        mem_done  = (fsm_q == DONE);
        busy      = (fsm_q != IDLE);
        mem_fault = mem_done & fault_q;
    end

    always_comb begin
        armed_d     = armed_q;
        rd_d        = rd_q;
        st_d        = st_q;
        rw_d        = rw_q;
        wreg_d      = wreg_q;
        wf_d        = wf_q;
        word_addr_d = word_addr_q;
        off_d       = off_q;
        size_d      = size_q;
        uns_d       = uns_q;
        wdata_d     = wdata_q;
        rwdata_d    = rwdata_q;
        wb_data_d   = wb_data_q;
        rwo_d       = rwo_q;
        wro_d       = wro_q;
        wfo_d       = wfo_q;
        fault_d     = fault_q;

        if (state != MEM_STATE) begin
            armed_d = 1'b0;
        end else if (start) begin
            armed_d = 1'b1;
        end

        if (start) begin
            rd_d        = mem_read_in;
            st_d        = mem_write_in & ~mem_read_in;
            rw_d        = reg_write_in;
            wreg_d      = write_reg_in;
            wf_d        = writef_in;
            word_addr_d = mem_addr[31:2];
            off_d       = in_off;
            size_d      = in_size;
            uns_d       = load_unsigned;
            wdata_d     = mem_write_data;
            rwdata_d    = reg_write_data;
            fault_d     = in_fault;
            // Paths that skip the bus publish write-back values right away.
            if (!in_access || in_fault) begin
                wb_data_d = in_fault ? 32'd0 : reg_write_data;
                rwo_d     = reg_write_in & ~in_fault;
                wro_d     = write_reg_in;
                wfo_d     = writef_in;
            end
        end else if (handshake) begin
            wb_data_d = rd_q ? load_data : rwdata_q;
            rwo_d     = rw_q & ~st_q;
            wro_d     = wreg_q;
            wfo_d     = wf_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            armed_q     <= 1'b0;
            rd_q        <= 1'b0;
            st_q        <= 1'b0;
            rw_q        <= 1'b0;
            wreg_q      <= 5'd0;
            wf_q        <= 1'b0;
            word_addr_q <= 30'd0;
            off_q       <= 2'd0;
            size_q      <= MS_BYTE;
            uns_q       <= 1'b0;
            wdata_q     <= 32'd0;
            rwdata_q    <= 32'd0;
            wb_data_q   <= 32'd0;
            rwo_q       <= 1'b0;
            wro_q       <= 5'd0;
            wfo_q       <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            armed_q     <= armed_d;
            rd_q        <= rd_d;
            st_q        <= st_d;
            rw_q        <= rw_d;
            wreg_q      <= wreg_d;
            wf_q        <= wf_d;
            word_addr_q <= word_addr_d;
            off_q       <= off_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            wdata_q     <= wdata_d;
            rwdata_q    <= rwdata_d;
            wb_data_q   <= wb_data_d;
            rwo_q       <= rwo_d;
            wro_q       <= wro_d;
            wfo_q       <= wfo_d;
            fault_q     <= fault_d;
        end
    end

    assign reg_write_out = rwo_q;
    assign write_reg_out = wro_q;
    assign writef_out    = wfo_q;
    assign wb_data       = wb_data_q;

endmodule

`default_nettype wire

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the multi-cycle core, directly downstream of the execute stage. It consumes the execute stage's registered outputs while the sequencer `state` equals 3. It performs at most one load or store on the data-memory bus with a valid/ready handshake, aligns and extends load data, and hands the write-back value and destination to the write-back stage. It signals completion with a one-cycle `mem_done` pulse; the sequencer holds `state` at 3 until that pulse.

## Interface
Parameters:
- `MEM_STATE`, 3: sequencer value that enables this stage.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-low reset (asserted when 0).
- `state` in 3: core sequencer state.
- `mem_read_in`, `mem_write_in`, `reg_write_in` in 1 each: control from execute.
- `write_reg_in` in 5: destination register.
- `writef_in` in 1: destination is the FP register file.
- `mem_addr` in 32: byte address (ALU result).
- `mem_write_data` in 32: store data, right-justified.
- `reg_write_data` in 32: non-load write-back value.
- `mem_size` in 2: 0 = byte, 1 = half, 2 = word; 3 is treated as word.
- `load_unsigned` in 1: zero-extend loads.
- `dmem_req` out 1, `dmem_we` out 1, `dmem_addr` out 32, `dmem_wdata` out 32, `dmem_be` out 4: bus request.
- `dmem_ready` in 1, `dmem_rdata` in 32: bus response; read data is valid in the same cycle as `dmem_ready`.
- `reg_write_out` out 1, `write_reg_out` out 5, `writef_out` out 1, `wb_data` out 32: to write-back.
- `mem_done` out 1: completion pulse.
- `busy` out 1: FSM not IDLE.
- `mem_fault` out 1: misaligned access (see Configuration).

## Operation
FSM states: IDLE, REQ, DONE.
- **Arming flag:** the flag sets on start and clears whenever `state != MEM_STATE`. It guarantees exactly one access per entry into state 3.
- **Start condition:** IDLE & `state == MEM_STATE` & flag clear.
  - Latch all inputs on start.
  - Access (read or write) -> REQ.
  - Neither read nor write -> DONE with `wb_data = reg_write_data`.
  - `mem_read_in` and `mem_write_in` both high: treat as a read.
- **REQ:**
  - `dmem_req = 1`; `dmem_addr`, `dmem_we`, `dmem_be` and `dmem_wdata` are held stable until `dmem_ready`.
  - Handshake completes on `dmem_req & dmem_ready`. On a load, capture `dmem_rdata` through the lane aligner, then -> DONE.
- **DONE:** `mem_done = 1` for exactly one cycle; write-back outputs are valid; -> IDLE.
- **Store lanes:**
  - Byte: `dmem_be = 1 << addr[1:0]`, data replicated across all four lanes.
  - Half: `be = 4'b0011 << addr[1:0]`, data replicated twice.
  - Word: `be = 4'b1111`.
- **Bus address:** `dmem_addr = {mem_addr[31:2], 2'b00}`.
- **Load:** select the lane by `addr[1:0]`, then sign- or zero-extend to 32 bits.
- **Write-back qualifier:** `reg_write_out` is `reg_write_in` qualified as follows: forced 0 on a store or on a fault.
- **Output holding:** write-back outputs hold their value after DONE until the next DONE.

## Timing
- **Reset values:** all outputs 0; FSM IDLE; flag clear. Reset is asynchronous, so `dmem_req` drops immediately, even mid-REQ. The pending access is abandoned and the bus must tolerate the drop.
- **Non-memory path:** start at cycle 0, DONE (`mem_done`) at cycle 1.
- **Memory path:**
  - Start at cycle 0, REQ from cycle 1.
  - `dmem_ready` in REQ cycle k gives DONE at cycle k+1.
  - Minimum latency is 2 cycles from start to `mem_done`. There is no upper bound.
- **`busy`:** high in REQ and DONE.
- **Sequencer:** may leave state 3 in the cycle after `mem_done`. If `state` is still 3 after DONE, no restart occurs until `state` has left 3 and returned.
- **Late `dmem_ready`:** `dmem_ready` while not in REQ is ignored.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - A half access with `addr[0] = 1`, or a word access with `addr[1:0] != 0`, skips REQ and goes straight to DONE.
  - In that DONE: `mem_fault = 1` for the `mem_done` cycle, `reg_write_out = 0`, `wb_data = 0`.
- Undefined:
  - `mem_fault` is tied to 0.
  - Misaligned half/word accesses use `addr[1:0]` masked to the access size: half uses `addr[1]` only; word ignores both bits.

## Structure
- **Shared package `core_pkg`:**
  - `mem_size_t` (MS_BYTE, MS_HALF, MS_WORD).
  - `mem_fsm_t` (IDLE, REQ, DONE).
  - Constant `STATE_MEM = 3`, used as the default for `MEM_STATE`.
- **Sub-module `load_align`:** combinational; takes rdata, `addr[1:0]`, size and unsigned flag, and returns the 32-bit extended value.
- Store-lane generation stays inline.

## Test plan
- **Non-memory entry:** `state` 0->3, read=write=0, `reg_write_data=32'h1234_5678`, `reg_write_in=1`, `write_reg_in=5` -> `mem_done` at +1 cycle, `wb_data=32'h1234_5678`, `write_reg_out=5`; no `dmem_req`.
- **Signed byte load:** byte load, signed, `addr=32'h103`, `rdata=32'h80FF_0000`, ready after 3 wait cycles -> `dmem_addr=32'h100`, `wb_data=32'hFFFF_FF80`; with `load_unsigned=1` -> `32'h0000_0080`.
- **Half store:** half store, `addr=32'h202`, data `32'h0000_ABCD` -> `dmem_be=4'b1100`, `dmem_wdata=32'hABCD_ABCD`, `dmem_we=1`, `reg_write_out=0`.
- **Zero-wait word load:** word load with `dmem_ready` held high -> `mem_done` exactly 2 cycles after start. `state` held at 3 for 4 more cycles -> no second request.
- **Misaligned word:** word load at `32'h301` -> with `MEM_ALIGN_CHECK_EN`: no `dmem_req`, `mem_fault=1`, `reg_write_out=0`. Without it: request to `32'h300`, no fault.
- **Reset mid-access:** `rst` low during REQ -> `dmem_req`, `busy` and `mem_done` go to 0 asynchronously. After release with `state=3` -> a fresh access starts.
